// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers.
// Default widths for FIFO_DWIDTH / ARB_QWID when the build does not set them.
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 32
`endif
`ifndef ARB_QWID
`define ARB_QWID 1
`endif

package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int BEAT_W = 8;

  // Pointer increment that wraps at n, not at a power of two.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority scan: first set req bit at or after rr_ptr,
// wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int QWID = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [QWID-1:0] rr_ptr,
  output logic [QWID-1:0] w,
  output logic            any
);

  always_comb begin : scan
    int idx;
    w   = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        w   = QWID'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_fifo_arb.sv
// Round-robin FIFO-to-FIFO arbiter; pop and push are combinational.
// Define ARB_BURST_EN to hold a grant for up to BURST beats.
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 32
`endif
`ifndef ARB_QWID
`define ARB_QWID 1
`endif

module rr_fifo_arb
  import arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = `FIFO_DWIDTH,
  parameter int QWID  = `ARB_QWID,
  parameter int BURST = 4,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       empty,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       pop,
  input  logic                  out_full,
  output logic                  out_push,
  output logic [WIDTH-1:0]      data_out,
  output logic [QWID-1:0]       grant_id,
  output logic                  grant_vld,
  output logic [CNTW-1:0]       xfer_cnt
);

  logic [NREQ-1:0] req;
  logic [QWID-1:0] rr_ptr;
  logic [QWID-1:0] w;
  logic [QWID-1:0] sel;
  logic            any;
  logic            xfer;
  logic [CNTW-1:0] cnt;

`ifdef ARB_BURST_EN
  localparam logic [BEAT_W-1:0] BURST_L = BEAT_W'(BURST);

  arb_state_t        state;
  logic [QWID-1:0]   owner;
  logic [BEAT_W-1:0] beats;

  // While holding, only the owner may win.
  always_comb begin
    req = ~empty;
    if (state == HOLD) req = ~empty & (NREQ'(1) << owner);
  end
`else
  assign req = ~empty;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .QWID (QWID)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .w      (w),
    .any    (any)
  );

  assign xfer      = !rst && !out_full && any;
  assign pop       = xfer ? (NREQ'(1) << w) : '0;
  assign out_push  = xfer;
  assign grant_vld = xfer;
  assign grant_id  = xfer ? w : '0;
  assign sel       = xfer ? w : rr_ptr;
  assign data_out  = data_in[sel*WIDTH +: WIDTH];
  assign xfer_cnt  = cnt;

`ifdef ARB_BURST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      state  <= IDLE;
      owner  <= '0;
      beats  <= '0;
      cnt    <= '0;
    end else begin
      if (xfer) cnt <= cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            if (BURST_L == BEAT_W'(1)) begin
              rr_ptr <= QWID'(rr_next(int'(w), NREQ));
            end else begin
              state <= HOLD;
              owner <= w;
              beats <= BEAT_W'(1);
            end
          end
        end
        HOLD: begin
          if (xfer) begin
            if (beats + 1'b1 == BURST_L) begin
              state  <= IDLE;
              beats  <= '0;
              rr_ptr <= QWID'(rr_next(int'(owner), NREQ));
            end else begin
              beats <= beats + 1'b1;
            end
          end else if (empty[owner]) begin
            // Owner ran dry: give up the rest of the burst.
            state  <= IDLE;
            beats  <= '0;
            rr_ptr <= QWID'(rr_next(int'(owner), NREQ));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      cnt    <= '0;
    end else if (xfer) begin
      rr_ptr <= QWID'(rr_next(int'(w), NREQ));
      cnt    <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_fifo_arb.sv
// Directed bench for rr_fifo_arb (NREQ=2 and NREQ=3 instances).
// Burst scenarios run when ARB_BURST_EN is defined.
module tb_rr_fifo_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic [1:0]  empty2;
  logic [15:0] din2;
  logic [1:0]  pop2;
  logic        full2;
  logic        push2;
  logic [7:0]  dout2;
  logic [0:0]  gid2;
  logic        gvld2;
  logic [15:0] cnt2;

  logic [2:0]  empty3;
  logic [23:0] din3;
  logic [2:0]  pop3;
  logic        full3;
  logic        push3;
  logic [7:0]  dout3;
  logic [1:0]  gid3;
  logic        gvld3;
  logic [15:0] cnt3;

  int checks = 0;
  int errors = 0;

  assign din2 = {8'hB1, 8'hA0};
  assign din3 = {8'hC2, 8'hB1, 8'hA0};

  rr_fifo_arb #(
    .NREQ (2), .WIDTH (8), .QWID (1), .BURST (4), .CNTW (16)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty2),
    .data_in   (din2),
    .pop       (pop2),
    .out_full  (full2),
    .out_push  (push2),
    .data_out  (dout2),
    .grant_id  (gid2),
    .grant_vld (gvld2),
    .xfer_cnt  (cnt2)
  );

  rr_fifo_arb #(
    .NREQ (3), .WIDTH (8), .QWID (2), .BURST (4), .CNTW (16)
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty3),
    .data_in   (din3),
    .pop       (pop3),
    .out_full  (full3),
    .out_push  (push3),
    .data_out  (dout3),
    .grant_id  (gid3),
    .grant_vld (gvld3),
    .xfer_cnt  (cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dat(input int g);
    return 8'hA0 + 8'(g * 8'h11);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // g < 0 means no transfer expected this cycle.
  task automatic g2(input string tag, input int g);
    #1;
    if (g < 0) begin
      chk({tag, ".pop"}, 32'(pop2), 32'd0);
      chk({tag, ".push"}, 32'(push2), 32'd0);
      chk({tag, ".vld"}, 32'(gvld2), 32'd0);
    end else begin
      chk({tag, ".pop"}, 32'(pop2), 32'd1 << g);
      chk({tag, ".push"}, 32'(push2), 32'd1);
      chk({tag, ".vld"}, 32'(gvld2), 32'd1);
      chk({tag, ".gid"}, 32'(gid2), 32'(g));
      chk({tag, ".data"}, 32'(dout2), 32'(dat(g)));
    end
    tick();
  endtask

  task automatic g3(input string tag, input int g);
    #1;
    if (g < 0) begin
      chk({tag, ".pop"}, 32'(pop3), 32'd0);
      chk({tag, ".push"}, 32'(push3), 32'd0);
    end else begin
      chk({tag, ".pop"}, 32'(pop3), 32'd1 << g);
      chk({tag, ".push"}, 32'(push3), 32'd1);
      chk({tag, ".gid"}, 32'(gid3), 32'(g));
      chk({tag, ".data"}, 32'(dout3), 32'(dat(g)));
    end
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    empty2 = 2'b00;
    full2  = 1'b0;
    empty3 = 3'b111;
    full3  = 1'b0;
    tick();

    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst.pop", 32'(pop2), 32'd0);
      chk("rst.push", 32'(push2), 32'd0);
      chk("rst.vld", 32'(gvld2), 32'd0);
      chk("rst.gid", 32'(gid2), 32'd0);
      tick();
    end
    rst = 1'b0;
    chk("rst.cnt", 32'(cnt2), 32'd0);

`ifdef ARB_BURST_EN
    begin
      int seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      foreach (seq[i]) g2("burst", seq[i]);
    end
    chk("burst.cnt", 32'(cnt2), 32'd9);
    g2("b2", 0);
    full2 = 1'b1;
    g2("bstall", -1);
    g2("bstall", -1);
    full2 = 1'b0;
    g2("b3", 0);
    g2("b4", 0);
    g2("bnext", 1);
    g2("bnext", 1);
    g2("bnext", 1);
    g2("bnext", 1);
    g2("early", 0);
    g2("early", 0);
    chk("early.cnt", 32'(cnt2), 32'd18);
    empty2 = 2'b01;
    g2("bubble", -1);
    g2("after", 1);
    empty2 = 2'b00;
    g2("hold1", 1);
    rst = 1'b1;
    #1;
    chk("midrst.pop", 32'(pop2), 32'd0);
    chk("midrst.push", 32'(push2), 32'd0);
    tick();
    rst = 1'b0;
    chk("midrst.cnt", 32'(cnt2), 32'd0);
    g2("postrst", 0);
`else
    for (int i = 0; i < 6; i++) begin
      chk("fair.cnt", 32'(cnt2), 32'(i));
      g2("fair", i % 2);
    end
    chk("fair.cnt6", 32'(cnt2), 32'd6);
    full2 = 1'b1;
    repeat (3) g2("bp", -1);
    chk("bp.cnt", 32'(cnt2), 32'd6);
    full2 = 1'b0;
    g2("bp_rel", 0);
    empty2 = 2'b10;
    g2("skip", 0);
    empty2 = 2'b11;
    full2  = 1'b1;
    g2("idle", -1);
    empty2 = 2'b00;
    full2  = 1'b0;
    g2("arrive", 1);
    chk("cnt9", 32'(cnt2), 32'd9);
    empty2 = 2'b11;

    chk("n3.cnt0", 32'(cnt3), 32'd0);
    empty3 = 3'b110;
    g3("n3a", 0);
    empty3 = 3'b101;
    g3("n3b", 1);
    empty3 = 3'b011;
    g3("wrap", 2);
    empty3 = 3'b110;
    g3("wrap0", 0);
    empty3 = 3'b000;
    g3("rr1", 1);
    g3("rr2", 2);
    g3("rr0", 0);
    empty3 = 3'b111;
    g3("none", -1);
    chk("n3.cnt", 32'(cnt3), 32'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
